// File: rtl/mem_responder_if.sv
// CPU-side strobe bus and output-FIFO drain port of the memory responder.
// master = controller/datapath plus FIFO consumer, slave = mem_responder.
interface mem_responder_if #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 8
);
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data_in;
  logic              mem_rd;
  logic              mem_wr;
  logic [DWIDTH-1:0] data_out;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output addr, data_in, mem_rd, mem_wr, out_ready,
    input  data_out, out_data, out_valid
  );

  modport slave (
    input  addr, data_in, mem_rd, mem_wr, out_ready,
    output data_out, out_data, out_valid
  );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: RAM with a 1-cycle registered read, edge-qualified writes,
// a memory-mapped output FIFO and a status register. Optional `LOADER_EN adds a RAM preload port.
module mem_responder #(
  parameter int unsigned       AWIDTH     = 5,
  parameter int unsigned       DWIDTH     = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [AWIDTH-1:0] IO_ADDR    = AWIDTH'(5'h1E),
  parameter logic [AWIDTH-1:0] STAT_ADDR  = AWIDTH'(5'h1F)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef LOADER_EN
  input  logic              ld_en,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_data,
`endif
  mem_responder_if.slave    bus
);

  localparam int unsigned RAM_DEPTH = 1 << AWIDTH;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  logic [DWIDTH-1:0] r_ram  [RAM_DEPTH];
  logic [DWIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_wr_q;
  logic              r_overflow;
  logic              r_conflict;
  logic [DWIDTH-1:0] r_data_out;

  logic              w_ld_en;
  logic              w_rd;
  logic              w_wr_act;
  logic              w_conflict;
  logic              w_is_io;
  logic              w_is_stat;
  logic              w_ram_we;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_stat_clr;
  logic              w_empty;
  logic              w_full;
  logic [DWIDTH-1:0] w_status;
  logic [DWIDTH-1:0] w_rd_src;

`ifdef LOADER_EN
  assign w_ld_en = ld_en;
`else
  assign w_ld_en = 1'b0;
`endif

  // Decode strobes; a held mem_wr acts only in its first cycle
  always_comb begin
    w_rd       = bus.mem_rd && !bus.mem_wr && !w_ld_en;
    w_wr_act   = bus.mem_wr && !r_wr_q && !w_ld_en;
    w_conflict = bus.mem_rd && bus.mem_wr && !w_ld_en;
    w_is_io    = (bus.addr == IO_ADDR);
    w_is_stat  = (bus.addr == STAT_ADDR);
    w_ram_we   = w_wr_act && !w_is_io && !w_is_stat;
    w_push_req = w_wr_act && w_is_io;
    w_stat_clr = w_wr_act && w_is_stat;
    w_empty    = (r_count == '0);
    w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    w_pop      = !w_empty && bus.out_ready;
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
  end

  // Status word and read-source mux
  always_comb begin
    w_status = DWIDTH'({r_overflow, r_conflict, w_full, 5'(r_count)});
    w_rd_src = r_ram[bus.addr];
    if (w_is_io) begin
      w_rd_src = '0;
    end else if (w_is_stat) begin
      w_rd_src = w_status;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // RAM array is intentionally not reset
  always_ff @(posedge clk) begin
`ifdef LOADER_EN
    if (ld_en) begin
      r_ram[ld_addr] <= ld_data;
    end else if (w_ram_we) begin
      r_ram[bus.addr] <= bus.data_in;
    end
`else
    if (w_ram_we) begin
      r_ram[bus.addr] <= bus.data_in;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_q     <= 1'b0;
      r_data_out <= '0;
      r_overflow <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_wr_q <= bus.mem_wr && !w_ld_en;
      if (w_ld_en) begin
        r_data_out <= '0;
      end else if (w_rd) begin
        r_data_out <= w_rd_src;
      end
      // A conflict in the same cycle as a status clear remains recorded
      if (w_stat_clr) begin
        r_overflow <= 1'b0;
        r_conflict <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_conflict) begin
        r_conflict <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.data_in;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reads, edge-qualified writes, output FIFO,
// conflict/status handling and asynchronous reset.
module tb_mem_responder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_responder_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

`ifdef LOADER_EN
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  mem_responder dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .bus(bus.slave)
  );
`else
  mem_responder dut (
    .clk(clk), .rst(rst),
    .bus(bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.addr    = a;
    bus.data_in = d;
    bus.mem_wr  = 1'b1;
    tick();
    bus.mem_wr  = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    bus.addr   = a;
    bus.mem_rd = 1'b1;
    tick();
    bus.mem_rd = 1'b0;
    d = bus.data_out;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst           = 1'b0;
    bus.addr      = '0;
    bus.data_in   = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef LOADER_EN
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
`endif
    tick();
    tick();
    total++;
    if (bus.data_out !== 8'h00) begin
      bad++; $display("FAIL reset_data_out: got %h want 00", bus.data_out);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      bad++; $display("FAIL reset_fifo: got valid=%b data=%h want 0/00", bus.out_valid, bus.out_data);
    end
    #2 rst = 1'b1;
    tick();
    rd(5'h1F, d);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL reset_status: got %h want 00", d);
    end
  endtask

  task automatic test_read();
    wr(5'd3, 8'hA5);
    bus.addr   = 5'd3;
    bus.mem_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.data_out !== 8'hA5) begin
        bad++; $display("FAIL read_cycle%0d: got %h want A5", i, bus.data_out);
      end
    end
    bus.mem_rd = 1'b0;
    bus.addr   = 5'd5;
    tick();
    tick();
    total++;
    if (bus.data_out !== 8'hA5) begin
      bad++; $display("FAIL read_hold: got %h want A5", bus.data_out);
    end
  endtask

  task automatic test_write_once();
    logic [7:0] d;
    bus.addr    = 5'd7;
    bus.data_in = 8'h3C;
    bus.mem_wr  = 1'b1;
    tick();
    bus.data_in = 8'h99;
    tick();
    bus.mem_wr  = 1'b0;
    tick();
    rd(5'd7, d);
    total++;
    if (d !== 8'h3C) begin
      bad++; $display("FAIL write_once: got %h want 3C", d);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d;
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.out_ready = 1'b0;
    foreach (words[i]) wr(5'h1E, words[i]);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
      bad++; $display("FAIL fifo_head: got valid=%b data=%h want 1/11", bus.out_valid, bus.out_data);
    end
    rd(5'h1F, d);
    total++;
    if (d !== 8'h24) begin
      bad++; $display("FAIL fifo_full_status: got %h want 24", d);
    end
    wr(5'h1E, 8'h55);
    rd(5'h1F, d);
    total++;
    if (d !== 8'hA4) begin
      bad++; $display("FAIL fifo_overflow_status: got %h want A4", d);
    end
    rd(5'h1E, d);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL io_read_zero: got %h want 00", d);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] d;
    logic [7:0] exp_full [4];
    logic [7:0] exp_mid  [2];
    exp_full = '{8'h22, 8'h33, 8'h44, 8'h66};
    exp_mid  = '{8'h88, 8'h99};
    // push into a full FIFO while popping
    bus.addr      = 5'h1E;
    bus.data_in   = 8'h66;
    bus.mem_wr    = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.mem_wr    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rd(5'h1F, d);
    total++;
    if (d !== 8'hA4) begin
      bad++; $display("FAIL full_push_pop_status: got %h want A4", d);
    end
    foreach (exp_full[i]) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_full[i]) begin
        bad++; $display("FAIL drain_full%0d: got valid=%b data=%h want 1/%h", i, bus.out_valid, bus.out_data, exp_full[i]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      bad++; $display("FAIL drain_empty: got valid=%b data=%h want 0/00", bus.out_valid, bus.out_data);
    end
    // push into empty FIFO: visible only after the edge
    bus.addr    = 5'h1E;
    bus.data_in = 8'h77;
    bus.mem_wr  = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL empty_push_bypass: got valid=%b want 0", bus.out_valid);
    end
    tick();
    bus.mem_wr = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h77) begin
      bad++; $display("FAIL empty_push_visible: got valid=%b data=%h want 1/77", bus.out_valid, bus.out_data);
    end
    tick();
    wr(5'h1E, 8'h88);
    // push and pop at count 2
    bus.addr      = 5'h1E;
    bus.data_in   = 8'h99;
    bus.mem_wr    = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.mem_wr    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rd(5'h1F, d);
    total++;
    if (d !== 8'h82) begin
      bad++; $display("FAIL mid_push_pop_status: got %h want 82", d);
    end
    foreach (exp_mid[i]) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_mid[i]) begin
        bad++; $display("FAIL drain_mid%0d: got valid=%b data=%h want 1/%h", i, bus.out_valid, bus.out_data, exp_mid[i]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    rd(5'd3, d);
    bus.addr    = 5'd9;
    bus.data_in = 8'h5A;
    bus.mem_rd  = 1'b1;
    bus.mem_wr  = 1'b1;
    tick();
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    total++;
    if (bus.data_out !== 8'hA5) begin
      bad++; $display("FAIL conflict_hold: got %h want A5", bus.data_out);
    end
    tick();
    rd(5'd9, d);
    total++;
    if (d !== 8'h5A) begin
      bad++; $display("FAIL conflict_write: got %h want 5A", d);
    end
    rd(5'h1F, d);
    total++;
    if (d !== 8'hC0) begin
      bad++; $display("FAIL conflict_status: got %h want C0", d);
    end
    wr(5'h1F, 8'hFF);
    rd(5'h1F, d);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL status_clear: got %h want 00", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    wr(5'h1E, 8'h11);
    wr(5'h1E, 8'h22);
    rd(5'd3, d);
    bus.addr    = 5'h1E;
    bus.data_in = 8'h33;
    bus.mem_wr  = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.data_out !== 8'h00) begin
      bad++; $display("FAIL async_reset: got valid=%b data=%h dout=%h want 0/00/00", bus.out_valid, bus.out_data, bus.data_out);
    end
    bus.mem_wr = 1'b0;
    tick();
    #2 rst = 1'b1;
    tick();
    rd(5'h1F, d);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL reset_mid_status: got %h want 00", d);
    end
    rd(5'd3, d);
    total++;
    if (d !== 8'hA5) begin
      bad++; $display("FAIL ram_retained: got %h want A5", d);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read();
    test_write_once();
    test_fifo_full();
    test_push_pop();
    test_conflict();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
